// File: rtl/fp32_pkg.sv
// Shared fp32 types and constants for the sequential log2 unit and its
// fixed-point normalizer.
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP32_POS_INF = 32'h7F800000;
    localparam logic [31:0] FP32_NEG_INF = 32'hFF800000;
    localparam int          FP32_BIAS    = 127;

    typedef enum logic [1:0] {IDLE, ITERATE, NORMALIZE} log_state_t;

    // Operand classes whose log2 result is forced rather than computed.
    typedef enum logic [1:0] {SPC_NONE, SPC_NEG_INF, SPC_NAN, SPC_POS_INF} log_spc_t;

    function automatic log_spc_t log2_classify(input fp32_t a);
        log_spc_t c;
        if (a.exp == 8'd0)                        c = SPC_NEG_INF;  // zeros and flushed subnormals
        else if (a.exp == 8'hFF && a.mant != '0)  c = SPC_NAN;
        else if (a.sign)                          c = SPC_NAN;      // includes -inf
        else if (a.exp == 8'hFF)                  c = SPC_POS_INF;
        else                                      c = SPC_NONE;
        return c;
    endfunction

endpackage

// File: rtl/fixed_to_fp32.sv
// Combinational signed fixed-point (IW integer bits, FW fraction bits) to fp32
// converter; truncates toward zero, zero maps to +0.
module fixed_to_fp32
    import fp32_pkg::*;
#(
    parameter int FW = 24,
    parameter int IW = 9
) (
    input  logic [IW+FW-1:0] fixed_i,
    output logic [31:0]      fp_o
);
    localparam int W  = IW + FW;
    localparam int PW = $clog2(W);

    logic          neg;
    logic [W-1:0]  mag;
    logic [PW-1:0] lead;
    logic [W+22:0] ext;
    logic [22:0]   mant;
    logic [7:0]    exp_w;
    logic          unused_ext;

    always_comb begin
        neg  = fixed_i[W-1];
        mag  = neg ? (~fixed_i + {{(W-1){1'b0}}, 1'b1}) : fixed_i;
        lead = '0;
        for (int i = 0; i < W; i++)
            if (mag[i]) lead = PW'(i);
        // Leading one lands at the top bit; the 23 bits below it are the mantissa.
        ext   = {mag, 23'b0} << (PW'(W - 1) - lead);
        mant  = ext[W+21 -: 23];
        exp_w = 8'(FP32_BIAS - FW + int'(lead));
        fp_o  = (mag == '0) ? 32'h0 : {neg, exp_w, mant};
    end

    assign unused_ext = ^ext[W-2:0];

endmodule

// File: rtl/fp_log2_iter.sv
// Sequential fp32 log2: one fractional bit per cycle by repeated mantissa
// squaring, then a single normalize cycle back to fp32.
module fp_log2_iter
    import fp32_pkg::*;
#(
    parameter int ITER   = 24,
    parameter int MANT_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] inputA,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);
    localparam int CW = $clog2(ITER + 1);

    log_state_t          state_q, state_d;
    log_spc_t            spc_q, spc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [MANT_W-1:0]   y_q, y_d;
    logic [ITER-1:0]     frac_q, frac_d;
    logic signed [8:0]   e_q, e_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [31:0]         out_q, out_d;

    fp32_t               a;
    logic [MANT_W+23:0]  y_init;
    logic [2*MANT_W-1:0] prod;
    logic [31:0]         norm_fp;
    logic                unused_prod;

    assign a      = fp32_t'(inputA);
    assign y_init = {1'b1, a.mant, {MANT_W{1'b0}}};
    assign prod   = {{MANT_W{1'b0}}, y_q} * {{MANT_W{1'b0}}, y_q};
    assign unused_prod = ^prod[MANT_W-2:0];

    // e <<< ITER plus a non-negative frac is just the concatenation.
    fixed_to_fp32 #(.FW(ITER), .IW(9)) u_norm (
        .fixed_i ({e_q, frac_q}),
        .fp_o    (norm_fp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            spc_q   <= SPC_NONE;
            cnt_q   <= '0;
            y_q     <= '0;
            frac_q  <= '0;
            e_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            spc_q   <= spc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            frac_q  <= frac_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        spc_d   = spc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        frac_d  = frac_q;
        e_d     = e_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                // busy stays up through the done cycle, so start is refused there.
                if (done_q) begin
                    busy_d = 1'b0;
                end else if (start && !busy_q) begin
                    spc_d   = log2_classify(a);
                    e_d     = 9'(a.exp) - 9'(FP32_BIAS);
                    y_d     = y_init[MANT_W+23 -: MANT_W];
                    frac_d  = '0;
                    cnt_d   = CW'(ITER);
                    busy_d  = 1'b1;
                    state_d = ITERATE;
                end
            end
            ITERATE: begin
                frac_d = {frac_q[ITER-2:0], prod[2*MANT_W-1]};
                y_d    = prod[2*MANT_W-1] ? prod[2*MANT_W-1 -: MANT_W]
                                          : prod[2*MANT_W-2 -: MANT_W];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = NORMALIZE;
            end
            NORMALIZE: begin
                case (spc_q)
                    SPC_NEG_INF: out_d = FP32_NEG_INF;
                    SPC_NAN:     out_d = FP32_QNAN;
                    SPC_POS_INF: out_d = FP32_POS_INF;
                    default:     out_d = norm_fp;
                endcase
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: doc/fp_log2_iter.md
Name: fp_log2_iter

Overview:
- Sequential IEEE-754 single-precision base-2 logarithm unit: out = log2(inputA).
- Inverse companion to the combinational power block: pow maps (A,B) to A^B, this block recovers exponents (log_A(x) = log2(x)/log2(A) via the existing divider).
- Computes the fractional log by iterative mantissa squaring, one result bit per cycle, then normalizes the fixed-point result back to fp32.
- Multi-cycle start/done handshake so one squarer is reused, instead of a large combinational path.

Parameters:
ITER, 24, number of fractional result bits produced (one per iteration cycle); legal range 8..28
MANT_W, 24, working width of the squared mantissa (hidden one included); truncated after each square

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; accepted only when busy=0
inputA  input  32  fp32 operand, sampled on the accepted start cycle
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when out is updated
out  output  32  fp32 result, held until the next done

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, out=32'h0. Reset mid-operation aborts; no done is issued.
- FSM IDLE -> ITERATE -> NORMALIZE -> IDLE.
- IDLE: on start, latch the operand, decode it, set busy=1, and go to ITERATE. The iteration counter loads ITER.
- ITERATE (exactly ITER cycles):
  - y = y*y, a MANT_W x MANT_W product of 2*MANT_W bits.
  - If product MSB=1: frac bit=1 and y = upper MANT_W bits.
  - Else: frac bit=0 and y = the bits one position lower.
  - Bits shift into the frac register MSB-first.
- NORMALIZE (1 cycle):
  - fixed = (e_unbiased <<< ITER) + frac, as a signed (9+ITER)-bit value.
  - sign = fixed<0; magnitude = |fixed|.
  - Leading-one detect, shift, truncate toward zero (no rounding).
  - Exponent = 127 + (position of leading one - ITER).
  - Write out, pulse done, clear busy, return to IDLE.
- Latency: accepted start at cycle 0 gives done at cycle ITER+2 (26 by default). Latency is fixed for every input, special cases included.
- start while busy=1 is ignored: no queuing, no effect on the operation in flight.
- start on the same cycle as done is impossible, because busy is still 1 that cycle. A start one cycle after done is accepted.
- Special cases are decoded in IDLE; their result is forced in NORMALIZE:
  - +0, -0, subnormal (flushed to zero) -> 32'hFF800000 (-inf)
  - negative nonzero, including -inf -> 32'h7FC00000 (qNaN)
  - NaN -> 32'h7FC00000
  - +inf -> 32'h7F800000
  - 1.0 gives fixed=0 -> 32'h00000000 (+0, never -0)
- Exact powers of two have frac=0 and produce exact integer results.
- Accuracy for normal inputs: |error| <= 2^-(ITER-2) absolute.

Decomposition:
- Package fp32_pkg holds:
  - fp32_t packed struct {sign, exp[7:0], mant[22:0]}
  - constants FP32_QNAN=32'h7FC00000, FP32_POS_INF=32'h7F800000, FP32_NEG_INF=32'hFF800000, FP32_BIAS=127
  - state enum log_state_t {IDLE, ITERATE, NORMALIZE}
- Sub-module fixed_to_fp32: combinational signed fixed-point to fp32 normalizer (leading-one detect, shift, exponent build), parameterized on the fractional width. It is reusable by future exp/pow-sequential blocks.

Test Plan:
- inputA=32'h40000000 (2.0), start pulse -> done exactly 26 cycles later, out=32'h3F800000 (1.0), busy low the cycle after.
- inputA=8.0 (32'h41000000) -> out=32'h40400000 (3.0). inputA=0.25 (32'h3E800000) -> out=32'hC0000000 (-2.0). inputA=1.0 -> out=32'h00000000.
- inputA=12.5135025 (3^2.3) -> out within 1e-5 of 3.645410. inputA=2.2360680 -> out within 1e-5 of 1.160964.
- Specials, each back-to-back with start one cycle after the previous done:
  - +0 -> FF800000
  - -2.0 -> 7FC00000
  - +inf -> 7F800000
  - NaN 7FC00001 -> 7FC00000
  - subnormal 00000001 -> FF800000
- Start 2.0, then start with 8.0 at cycle 5 while busy -> single done at cycle 26 with out=3F800000; no second done.
- Start 8.0, assert rst at cycle 10 for 2 cycles -> out=0, busy=0, done never pulses. A new start of 2.0 afterwards -> 3F800000 after 26 cycles.
